// File: rtl/pb_pkg.sv
// Shared push-button definitions: gesture FSM states and event codes.
// Also used by the debouncer wrapper to tag decoded gestures.
package pb_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } pb_state_t;

    localparam logic [2:0] EV_NONE   = 3'd0;
    localparam logic [2:0] EV_SHORT  = 3'd1;
    localparam logic [2:0] EV_DOUBLE = 3'd2;
    localparam logic [2:0] EV_LONG   = 3'd3;
    localparam logic [2:0] EV_REPEAT = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pb_gesture_decoder.sv
// Classifies debounced press/release strobes into short/double/long/repeat pulses.
// Latency: long LONG_CYCLES after press, short DCLICK_CYCLES after release, double 1 cycle.
// No backpressure: strobes are consumed every cycle, pulses are fire-and-forget.
module pb_gesture_decoder
    import pb_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_down,
    input  logic pb_up,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam int MAX_CYCLES = max3(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES);
    localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] DCLICK_TC = CW'(DCLICK_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);

    pb_state_t     state;
    logic [CW-1:0] cnt;

    // Simultaneous press and release is a protocol violation: treat as neither.
    logic down_ev;
    logic up_ev;
    assign down_ev = pb_down & ~pb_up;
    assign up_ev   = pb_up & ~pb_down;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (down_ev) begin
                        state <= PRESSED;
                        busy  <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (up_ev) begin
                        state <= WAIT_SECOND;
                        cnt   <= '0;
                    end else if (cnt == LONG_TC) begin
                        state      <= LONG_HELD;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (up_ev) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == REPEAT_TC) begin
                        cnt          <= '0;
                        repeat_pulse <= REPEAT_EN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_SECOND: begin
                    // A press on the terminal cycle still counts as the second click.
                    if (down_ev) begin
                        state <= SECOND_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DCLICK_TC) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        short_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SECOND_PRESSED: begin
                    cnt <= '0;
                    if (up_ev) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        double_press <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
